// File: rtl/result_display_driver.sv
// Signed binary result -> BCD digits via a sequential double-dabble engine,
// with a registered, multiplexed common-anode 7-segment scan including a sign position.
module result_display_driver #(
    parameter int WIDTH       = 14,
    parameter int NDIG        = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      value_in,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic [4*NDIG-1:0]     bcd_out,
    output logic                  neg_out,
    output logic [6:0]            seg,
    output logic [NDIG:0]         an
);

    localparam int ITW = $clog2(WIDTH + 1);
    localparam int CW  = $clog2(REFRESH_DIV);
    localparam int SW  = $clog2(NDIG + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ABS   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_capture;
    logic                 w_abs;
    logic                 w_shift;
    logic                 w_commit;

    logic [WIDTH-1:0]     r_value;
    logic [WIDTH-1:0]     r_mag;
    logic                 r_sign;
    logic                 r_nz;
    logic [4*NDIG-1:0]    r_scratch;
    logic [ITW-1:0]       r_iter;
    logic [4*NDIG-1:0]    w_adj;
    logic [4*NDIG-1:0]    w_scr_next;

    logic                 r_busy;
    logic                 r_done;
    logic [4*NDIG-1:0]    r_bcd;
    logic                 r_neg;

    logic [CW-1:0]        r_refresh;
    logic [SW-1:0]        r_scan;
    logic [SW-1:0]        w_pos;
    logic [4*NDIG-1:0]    w_upper;
    logic                 w_show;
    logic [6:0]           w_seg;
    logic [NDIG:0]        w_an;
    logic [6:0]           r_seg;
    logic [NDIG:0]        r_an;

    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = 7'h7F;
        endcase
        return code;
    endfunction

    // Conversion FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and datapath strobes
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_abs        = 1'b0;
        w_shift      = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load) begin
                    w_next_state = ST_ABS;
                    w_capture    = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ABS: begin
                w_abs        = 1'b1;
                w_next_state = ST_SHIFT;
            end
            ST_SHIFT: begin
                w_shift = 1'b1;
                if (r_iter == ITW'(WIDTH - 1)) begin
                    w_next_state = ST_DONE;
                    w_commit     = 1'b1;
                end else begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Add-3 correction on every scratch digit, then the shifted-in magnitude MSB
    always_comb begin
        w_adj = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (r_scratch[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
            end else begin
                w_adj[4*k +: 4] = r_scratch[4*k +: 4];
            end
        end
        w_scr_next = {w_adj[4*NDIG-2:0], r_mag[WIDTH-1]};
    end

    // Double-dabble datapath; the magnitude is kept as unsigned so -2^(WIDTH-1) survives negation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value   <= '0;
            r_mag     <= '0;
            r_sign    <= 1'b0;
            r_nz      <= 1'b0;
            r_scratch <= '0;
            r_iter    <= '0;
        end else if (w_capture) begin
            r_value <= value_in;
        end else if (w_abs) begin
            r_mag     <= r_value[WIDTH-1] ? (~r_value + {{(WIDTH-1){1'b0}}, 1'b1}) : r_value;
            r_sign    <= r_value[WIDTH-1];
            r_nz      <= |r_value;
            r_scratch <= '0;
            r_iter    <= '0;
        end else if (w_shift) begin
            r_scratch <= w_scr_next;
            r_mag     <= {r_mag[WIDTH-2:0], 1'b0};
            r_iter    <= r_iter + ITW'(1);
        end else begin
            r_iter <= r_iter;
        end
    end

    // Committed result registers; digits land together with the done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_bcd  <= '0;
            r_neg  <= 1'b0;
        end else begin
            r_busy <= (w_next_state != ST_IDLE);
            r_done <= w_commit;
            if (w_commit) begin
                r_bcd <= w_scr_next;
                r_neg <= r_sign & r_nz;
            end else begin
                r_bcd <= r_bcd;
                r_neg <= r_neg;
            end
        end
    end

    // Free-running refresh divider and scan position
    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh <= '0;
            r_scan    <= '0;
        end else if (r_refresh == CW'(REFRESH_DIV - 1)) begin
            r_refresh <= '0;
            r_scan    <= (r_scan == SW'(NDIG)) ? '0 : r_scan + SW'(1);
        end else begin
            r_refresh <= r_refresh + CW'(1);
        end
    end

    // Segment pattern for the current position; leading zeros above the units blank
    always_comb begin
        w_pos   = '0;
        w_upper = '0;
        w_show  = 1'b0;
        w_seg   = 7'h7F;
        if (r_scan < SW'(NDIG)) begin
            w_pos = r_scan;
        end else begin
            w_pos = '0;
        end
        w_upper = r_bcd >> {w_pos, 2'b00};
        w_show  = (w_pos == '0) | (|w_upper);
        if (r_scan == SW'(NDIG)) begin
            w_seg = r_neg ? 7'h3F : 7'h7F;
        end else if (w_show) begin
            w_seg = seg_code(w_upper[3:0]);
        end else begin
            w_seg = 7'h7F;
        end
        w_an = ~({{NDIG{1'b0}}, 1'b1} << r_scan);
    end

    // Registered display drive
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= 7'h7F;
            r_an  <= '1;
        end else begin
            r_seg <= w_seg;
            r_an  <= w_an;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign bcd_out = r_bcd;
    assign neg_out = r_neg;
    assign seg     = r_seg;
    assign an      = r_an;

endmodule
